// File: rtl/wb_master_burst_pkg.sv
// wb_defs: FSM state encodings and completion status codes
// shared by the Wishbone burst initiator and its interface.
package wb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] STS_OK      = 2'd0;
  localparam logic [1:0] STS_BUS_ERR = 2'd1;
  localparam logic [1:0] STS_TIMEOUT = 2'd2;

endpackage

// File: rtl/wb_master_burst_if.sv
// wb_master_burst_if: command, write/read streams, status and
// Wishbone bus. master = initiator side, slave = environment side.
interface wb_master_burst_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 8
);
  import wb_defs::*;

  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic                    cmd_we;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic                    cmd_valid;
  logic                    cmd_ready;

  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_valid;
  logic                    wr_ready;

  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_ready;

  logic                    done_o;
  logic [1:0]              sts_o;
  logic                    busy_o;

  logic [ADDR_WIDTH-1:0]   adr_o;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic [SELECT_WIDTH-1:0] sel_o;
  logic                    we_o;
  logic                    stb_o;
  logic                    cyc_o;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic                    ack_i;
  logic                    err_i;

  modport master (
    input  cmd_addr, cmd_len, cmd_we, cmd_sel,
    input  cmd_valid, wr_data, wr_valid, rd_ready,
    input  dat_i, ack_i, err_i,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output done_o, sts_o, busy_o,
    output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_we, cmd_sel,
    output cmd_valid, wr_data, wr_valid, rd_ready,
    output dat_i, ack_i, err_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  done_o, sts_o, busy_o,
    input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
  );

endinterface

// File: rtl/wb_master_burst.sv
// wb_master_burst: Wishbone classic burst initiator, one cyc per command.
// Ports: clk, rst (sync, active-high), bus (wb_master_burst_if.master).
module wb_master_burst
  import wb_defs::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_master_burst_if.master     bus
);

  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                  state_q, state_d;
  logic                    init_q;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    we_q, we_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]           to_q, to_d;
  logic                    done_q, done_d;
  logic [1:0]              sts_q, sts_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      sts_q   <= STS_OK;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      done_q  <= done_d;
      sts_q   <= sts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    done_d  = 1'b0;
    sts_d   = sts_q;
    unique case (state_q)
      IDLE: begin
        if (init_q && bus.cmd_valid) begin
          adr_d   = bus.cmd_addr;
          cnt_d   = bus.cmd_len;
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          to_d    = '0;
          state_d = bus.cmd_we ? FETCH : XFER;
        end
      end
      FETCH: begin
        if (bus.wr_valid) begin
          dat_d   = bus.wr_data;
          to_d    = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // err_i has priority over a simultaneous ack_i
        if (bus.err_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          sts_d   = STS_BUS_ERR;
        end else if (bus.ack_i) begin
          adr_d = adr_q + ADDR_WIDTH'(SELECT_WIDTH);
          if (!we_q) begin
            rdat_d  = bus.dat_i;
            state_d = DRAIN;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            sts_d   = STS_OK;
          end else begin
            cnt_d   = cnt_q - LEN_WIDTH'(1);
            state_d = FETCH;
          end
        end else begin
          // abort on the TIMEOUT-th strobe cycle without response
          to_d = to_q + TW'(1);
          if (TIMEOUT != 0 && to_d == TW'(TIMEOUT)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            sts_d   = STS_TIMEOUT;
          end
        end
      end
      DRAIN: begin
        if (bus.rd_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            sts_d   = STS_OK;
          end else begin
            cnt_d   = cnt_q - LEN_WIDTH'(1);
            to_d    = '0;
            state_d = XFER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = init_q && (state_q == IDLE);
  assign bus.wr_ready  = (state_q == FETCH);
  assign bus.rd_valid  = (state_q == DRAIN);
  assign bus.rd_data   = rdat_q;
  assign bus.done_o    = done_q;
  assign bus.sts_o     = sts_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;
  assign bus.sel_o     = sel_q;
  assign bus.we_o      = we_q;
  assign bus.stb_o     = (state_q == XFER);
  assign bus.cyc_o     = (state_q != IDLE);

endmodule

// File: tb/tb_wb_master_burst.sv
// tb_wb_master_burst: directed + randomized bench with a word-memory
// Wishbone target and a reference memory model of the burst transfers.
module tb_wb_master_burst;
  import wb_defs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_master_burst_if bus ();

  wb_master_burst #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];
  logic [15:0] beat_adr[$];
  logic [31:0] beat_dat[$];
  logic [3:0]  beat_sel[$];
  logic [31:0] wq[$];
  logic [31:0] rq[$];

  int   stb_cnt  = 0;
  int   rises    = 0;
  int   done_cnt = 0;
  int   sbeat    = 0;
  int   wcnt     = 0;
  int   wmax     = 0;
  int   err_beat = -1;
  bit   never_ack = 1'b0;
  logic cyc_prev = 1'b0;
  logic [13:0] sidx;

  // Wishbone target: optional wait states, error on a chosen beat,
  // or silence; responses are single-cycle, driven at negedge.
  always @(negedge clk) begin
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.cyc_o && !cyc_prev) rises++;
    cyc_prev = bus.cyc_o;
    if (!(bus.cyc_o && bus.stb_o)) begin
      wcnt = $urandom_range(wmax, 0);
      if (!bus.cyc_o) sbeat = 0;
    end else begin
      stb_cnt++;
      if (wcnt > 0) begin
        wcnt--;
      end else if (!never_ack) begin
        if (sbeat == err_beat) begin
          bus.err_i = 1'b1;
        end else begin
          bus.ack_i = 1'b1;
          sidx = bus.adr_o[15:2];
          beat_adr.push_back(bus.adr_o);
          beat_sel.push_back(bus.sel_o);
          if (bus.we_o) begin
            for (int b = 0; b < 4; b++)
              if (bus.sel_o[b])
                mem[sidx][8*b +: 8] = bus.dat_o[8*b +: 8];
            beat_dat.push_back(bus.dat_o);
          end else begin
            bus.dat_i = mem[sidx];
            beat_dat.push_back(mem[sidx]);
          end
        end
        sbeat++;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic [15:0] a,
                           input logic [7:0]  l,
                           input logic        w,
                           input logic [3:0]  s);
    int n;
    @(negedge clk);
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_we    = w;
    bus.cmd_sel   = s;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input  logic [15:0] a,
                        input  logic [7:0]  l,
                        input  logic        w,
                        input  logic [3:0]  s,
                        input  int          stall,
                        output logic [1:0]  st);
    int   wi, sl, d0;
    bit   seen, holding;
    logic [31:0] hold;
    beat_adr.delete();
    beat_dat.delete();
    beat_sel.delete();
    rq.delete();
    stb_cnt = 0;
    rises   = 0;
    d0      = done_cnt;
    issue_cmd(a, l, w, s);
    wi = 0; sl = stall; seen = 0;
    holding = 0; hold = '0; st = 2'd3;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
      if (bus.done_o) begin
        seen = 1;
        st   = bus.sts_o;
        chk("cyc_at_done", 64'(bus.cyc_o), 64'(0));
        chk("rdy_at_done", 64'(bus.cmd_ready), 64'(1));
      end else begin
        if (bus.wr_ready) begin
          if (sl == 0) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wq[wi];
            wi++;
            sl = stall;
          end else sl--;
        end
        if (bus.rd_valid) begin
          if (holding)
            chk("rd_hold", 64'(bus.rd_data), 64'(hold));
          if (sl == 0) begin
            bus.rd_ready = 1'b1;
            rq.push_back(bus.rd_data);
            sl = stall;
            holding = 0;
          end else begin
            sl--;
            holding = 1;
            hold = bus.rd_data;
          end
        end
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - d0), 64'(1));
  endtask

  // Expected beats follow start + 4*k modulo 2^16; writes update the
  // reference memory under the byte select, reads compare against it.
  task automatic verify(input string       nm,
                        input logic [15:0] a,
                        input logic        w,
                        input logic [3:0]  s,
                        input logic [1:0]  st,
                        input logic [1:0]  xst,
                        input int          nb);
    logic [15:0] ea;
    chk({nm, "_sts"}, 64'(st), 64'(xst));
    chk({nm, "_beats"}, 64'(beat_adr.size()), 64'(nb));
    for (int k = 0; k < nb && k < beat_adr.size(); k++) begin
      ea = a + 16'(4 * k);
      chk({nm, "_adr"}, 64'(beat_adr[k]), 64'(ea));
      if (w) begin
        chk({nm, "_wdat"}, 64'(beat_dat[k]), 64'(wq[k]));
        chk({nm, "_sel"}, 64'(beat_sel[k]), 64'(s));
        for (int b = 0; b < 4; b++)
          if (s[b])
            ref_mem[ea[15:2]][8*b +: 8] = wq[k][8*b +: 8];
      end else if (k < rq.size()) begin
        chk({nm, "_rdat"}, 64'(rq[k]), 64'(ref_mem[ea[15:2]]));
      end
    end
    if (!w) chk({nm, "_nrd"}, 64'(rq.size()), 64'(nb));
  endtask

  task automatic quiet(input string nm);
    int n;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.wr_ready || bus.rd_valid) n++;
    end
    chk(nm, 64'(n), 64'(0));
  endtask

  task automatic fill_wq(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  logic [1:0]  st;
  logic [15:0] ra;
  logic [7:0]  rl;
  logic        rw;
  logic [3:0]  rs;
  int          wi0, d0;

  initial begin
    rst = 1'b1;
    bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.cmd_we = 1'b0; bus.cmd_sel = '0;
    bus.cmd_valid = 1'b0;
    bus.wr_data = '0; bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[4 + i] = 32'hA0 + 32'(i);
      ref_mem[4 + i] = 32'hA0 + 32'(i);
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rst_cyc", 64'(bus.cyc_o), 64'(0));
    chk("rst_stb", 64'(bus.stb_o), 64'(0));
    chk("rst_we", 64'(bus.we_o), 64'(0));
    chk("rst_adr", 64'(bus.adr_o), 64'(0));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_done", 64'(bus.done_o), 64'(0));
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_ready", 64'(bus.cmd_ready), 64'(1));

    // read 4 words from 0x0010
    do_cmd(16'h0010, 8'd3, 1'b0, 4'hF, 0, st);
    verify("rd4", 16'h0010, 1'b0, 4'hF, st, STS_OK, 4);
    chk("rd4_val0", 64'(rq[0]), 64'h0A0);
    chk("rd4_val3", 64'(rq[3]), 64'h0A3);
    chk("rd4_stb", 64'(stb_cnt), 64'(4));
    chk("rd4_cyc_cont", 64'(rises), 64'(1));

    // write 2 words across the address wrap, wr_valid stalled
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h12345678);
    do_cmd(16'hFFFC, 8'd1, 1'b1, 4'hF, 3, st);
    verify("wr_wrap", 16'hFFFC, 1'b1, 4'hF, st, STS_OK, 2);
    chk("wr_wrap_stb", 64'(stb_cnt), 64'(2));
    chk("wr_wrap_cyc", 64'(rises), 64'(1));
    do_cmd(16'hFFFC, 8'd1, 1'b0, 4'hF, 0, st);
    verify("rb_wrap", 16'hFFFC, 1'b0, 4'hF, st, STS_OK, 2);
    chk("rb_wrap0", 64'(rq[0]), 64'hDEADBEEF);
    chk("rb_wrap1", 64'(rq[1]), 64'h12345678);

    // read with rd_ready held off 5 cycles per beat
    ra = 16'($urandom) & 16'hFFFC;
    do_cmd(ra, 8'd2, 1'b0, 4'hF, 5, st);
    verify("rd_stall", ra, 1'b0, 4'hF, st, STS_OK, 3);
    chk("rd_stall_stb", 64'(stb_cnt), 64'(3));

    // bus error on beat 2 of 4, read then write
    err_beat = 1;
    do_cmd(16'h0100, 8'd3, 1'b0, 4'hF, 0, st);
    verify("rd_err", 16'h0100, 1'b0, 4'hF, st, STS_BUS_ERR, 1);
    quiet("rd_err_quiet");
    fill_wq(4);
    do_cmd(16'h0140, 8'd3, 1'b1, 4'hF, 0, st);
    verify("wr_err", 16'h0140, 1'b1, 4'hF, st, STS_BUS_ERR, 1);
    quiet("wr_err_quiet");
    err_beat = -1;

    // target never acks
    never_ack = 1'b1;
    do_cmd(16'h0180, 8'd3, 1'b0, 4'hF, 0, st);
    verify("rd_to", 16'h0180, 1'b0, 4'hF, st, STS_TIMEOUT, 0);
    chk("rd_to_stb", 64'(stb_cnt), 64'(8));
    fill_wq(1);
    do_cmd(16'h01C0, 8'd0, 1'b1, 4'h3, 0, st);
    verify("wr_to", 16'h01C0, 1'b1, 4'h3, st, STS_TIMEOUT, 0);
    chk("wr_to_stb", 64'(stb_cnt), 64'(8));
    never_ack = 1'b0;

    // randomized bursts with wait states and stalls
    wmax = 2;
    for (int t = 0; t < 10; t++) begin
      ra = 16'($urandom) & 16'hFFFC;
      rl = 8'($urandom_range(5, 0));
      rw = 1'($urandom);
      rs = rw ? 4'($urandom_range(15, 1)) : 4'hF;
      fill_wq(int'(rl) + 1);
      do_cmd(ra, rl, rw, rs, $urandom_range(2, 0), st);
      verify(rw ? "rnd_wr" : "rnd_rd", ra, rw, rs, st,
             STS_OK, int'(rl) + 1);
      if (rw) begin
        do_cmd(ra, rl, 1'b0, 4'hF, 0, st);
        verify("rnd_rb", ra, 1'b0, 4'hF, st, STS_OK,
               int'(rl) + 1);
      end
    end
    wmax = 0;

    // reset in the middle of a write burst
    fill_wq(4);
    beat_adr.delete();
    d0 = done_cnt;
    issue_cmd(16'h0200, 8'd3, 1'b1, 4'hF);
    wi0 = 0;
    for (int c = 0; c < 50 && beat_adr.size() < 2; c++) begin
      @(negedge clk);
      bus.wr_valid = 1'b0;
      if (bus.wr_ready) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wq[wi0];
        wi0++;
      end
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cyc", 64'(bus.cyc_o), 64'(0));
    chk("mid_rst_stb", 64'(bus.stb_o), 64'(0));
    chk("mid_rst_we", 64'(bus.we_o), 64'(0));
    chk("mid_rst_adr", 64'(bus.adr_o), 64'(0));
    chk("mid_rst_dat", 64'(bus.dat_o), 64'(0));
    chk("mid_rst_sel", 64'(bus.sel_o), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy_o), 64'(0));
    chk("mid_rst_wr_ready", 64'(bus.wr_ready), 64'(0));
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("mid_rst_done", 64'(bus.done_o), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt - d0), 64'(0));
    do_cmd(16'h3000, 8'd3, 1'b0, 4'hF, 1, st);
    verify("post_rst_rd", 16'h3000, 1'b0, 4'hF, st, STS_OK, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
